// File: rtl/fb_pkg.sv
// Shared widths, default latency and the per-cycle slot decision type for the
// frame-buffer arbiter.
package fb_pkg;
  localparam int FB_ADDR_W  = 20;
  localparam int FB_DATA_W  = 8;
  localparam int FB_MEM_LAT = 1;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_BLANK,
    SLOT_WRITE
  } slot_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// Two-entry write FIFO for the pixel writer; registered occupancy, async and
// sync clear.
module fb_wr_fifo #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              s_rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count,
  output logic              full,
  output logic              empty
);
  logic [ADDR_W-1:0] addr_q [2];
  logic [DATA_W-1:0] data_q [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (s_rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end
endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer SRAM arbiter: display reads always win, buffered writes fill
// the remaining cycles, pixels come out MEM_LAT clk after the read strobe.
//   slot       | meaning
//   SLOT_IDLE  | no memory access this cycle
//   SLOT_READ  | display fetch at disp_addr
//   SLOT_BLANK | blank pixel slot, nothing queued to write
//   SLOT_WRITE | pop FIFO head into the SRAM
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W  = FB_ADDR_W,
  parameter int DATA_W  = FB_DATA_W,
  parameter int MEM_LAT = FB_MEM_LAT
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              s_rst,
  input  logic              enable,
  input  logic              pixel_clk,
  input  logic              disp_active,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic [1:0]        wr_count
);
  slot_t             slot_d;
  slot_t             slot_q;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [MEM_LAT:0]  pipe_v;
  logic [MEM_LAT:0]  pipe_rd;

  assign wr_ready = ~fifo_full;
  assign pop      = (slot_d == SLOT_WRITE);

  fb_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .s_rst     (s_rst),
    .push      (wr_valid),
    .pop       (pop),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (wr_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Registered count gates the pop, so a fresh push is written no earlier
  // than the following clk.
  always_comb begin
    slot_d = SLOT_IDLE;
    if (enable) begin
      if (pixel_clk && disp_active) slot_d = SLOT_READ;
      else if (!fifo_empty)         slot_d = SLOT_WRITE;
      else if (pixel_clk)           slot_d = SLOT_BLANK;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      slot_q    <= SLOT_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pipe_v    <= '0;
      pipe_rd   <= '0;
    end else if (s_rst) begin
      slot_q    <= SLOT_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pipe_v    <= '0;
      pipe_rd   <= '0;
    end else begin
      slot_q <= slot_d;
      case (slot_d)
        SLOT_READ:  mem_addr <= disp_addr;
        SLOT_WRITE: begin
          mem_addr  <= head_addr;
          mem_wdata <= head_data;
        end
        default: ;
      endcase
      // Stage 0 lines up with the strobe; the last stage with returning data.
      pipe_v  <= {pipe_v[MEM_LAT-1:0], enable & pixel_clk};
      pipe_rd <= {pipe_rd[MEM_LAT-1:0], disp_active};
    end
  end

  assign mem_re    = (slot_q == SLOT_READ);
  assign mem_we    = (slot_q == SLOT_WRITE);
  assign pix_valid = pipe_v[MEM_LAT];
  assign pix_data  = (pipe_v[MEM_LAT] && pipe_rd[MEM_LAT]) ? mem_rdata : '0;
endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Frame-buffer memory arbiter between the display refresh path and a pixel writer. The display path reads on `pixel_clk` strobes from the row/column/address timer and always wins. The writer is buffered in a 2-entry FIFO and drained into free memory cycles. The block sits between the timing generator, the single-port frame-buffer SRAM and the pixel-producing logic.

## Interface
Parameters:
- `ADDR_W`, 20: frame-buffer address width (matches the timer address counter).
- `DATA_W`, 8: pixel width.
- `MEM_LAT`, 1: SRAM read latency in clk cycles, legal range 1..3.

Ports:
- `clk`  in  1  system clock (only clock).
- `n_rst`  in  1  reset, asynchronous, active-low.
- `s_rst`  in  1  synchronous clear; same effect as reset.
- `enable`  in  1  arbitration enable.
- `pixel_clk`  in  1  one-clk strobe from the timer divider, high every 2nd clk.
- `disp_active`  in  1  visible-region flag from the timer.
- `disp_addr`  in  ADDR_W  timer address counter value.
- `wr_valid`  in  1  writer request.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `wr_ready`  out  1  FIFO not full.
- `mem_addr`  out  ADDR_W  SRAM address.
- `mem_wdata`  out  DATA_W  SRAM write data.
- `mem_we`  out  1  SRAM write strobe.
- `mem_re`  out  1  SRAM read strobe.
- `mem_rdata`  in  DATA_W  SRAM read data.
- `pix_data`  out  DATA_W  pixel to DAC/output stage.
- `pix_valid`  out  1  `pix_data` qualifier.
- `wr_count`  out  2  FIFO occupancy, 0..2.

## Operation
- **Display slot** (`enable & pixel_clk & disp_active`): drive `mem_re=1` and `mem_addr=disp_addr`; this blocks any write that cycle.
- **Blank slot** (`enable & pixel_clk & ~disp_active`): no memory access. The cycle is free for writes. A zero pixel is scheduled with `pix_valid` on the same latency as a read.
- **Free cycle** (`enable`, no display read, `wr_count>0`): pop the FIFO head and drive `mem_we=1` with `mem_addr`/`mem_wdata` taken from the head.
- `mem_re` and `mem_we` are never both high.
- When no access is issued, `mem_addr`/`mem_wdata` hold their last value.
- **Push**: a write is accepted when `wr_valid & wr_ready`.
  - `wr_ready = (wr_count != 2)` and depends only on registered count; there is no pop-bypass when full.
  - A push to an empty FIFO is not written to memory in the same cycle. The earliest write is the next clk.
  - Simultaneous push and pop: count unchanged and order preserved.
- **`enable=0`**: no new memory operations. Pushes are still accepted until full. In-flight reads still complete and raise `pix_valid`.
- **`s_rst` or `n_rst`**: FIFO empties, the read pipeline clears and all outputs go to 0.
  - Exception: `wr_ready=1` during and after reset.
  - Reads in flight at reset are discarded.

## Timing
- Memory strobes are registered outputs, one clk after the slot decision. Slot inputs are sampled at clk N and strobes are visible at N+1.
- `pix_data`/`pix_valid` rise at N+1+MEM_LAT, and `pix_valid` is high for exactly one clk.
- Every `pixel_clk` strobe with `enable=1` yields exactly one `pix_valid` pulse, either read data or blank zero.
- Write bandwidth is at least 1 write per 2 clk in the active region and 1 per clk in blanking.
- A pushed entry reaches `mem_we` within 3 clk if `enable` stays high.
- Reset values: `mem_addr=0`, `mem_wdata=0`, `mem_we=0`, `mem_re=0`, `pix_data=0`, `pix_valid=0`, `wr_count=0`, `wr_ready=1`.

## Structure
- Package `fb_pkg`:
  - constants `FB_ADDR_W=20`, `FB_DATA_W=8`, `FB_MEM_LAT=1`;
  - enum `slot_t` {`SLOT_IDLE`, `SLOT_READ`, `SLOT_BLANK`, `SLOT_WRITE`}, used for the per-cycle decision register.
- Sub-module `fb_wr_fifo`: 2-entry FIFO with push/pop, registered count, `full`/`empty` flags, and async plus sync clear.
- Top level: slot decoder, registered memory strobes, and a MEM_LAT-deep valid/blank shift register that muxes `mem_rdata` or 0 into `pix_data`.

## Test plan
- **Reset mid-stream**: assert `n_rst=0` with 2 entries queued and a read in flight -> all outputs 0, `wr_ready=1`, no `pix_valid` afterwards.
- **Active-region read**: `pixel_clk` strobe with `disp_active=1`, `disp_addr=0x00123`, memory model returns 0xA5 -> `mem_re` at N+1 with `mem_addr=0x00123`, then `pix_valid` with `pix_data=0xA5` at N+2 (MEM_LAT=1).
- **Write vs. read collision**: push (0x00010, 0x3C) on the same clk as an active strobe -> `mem_re` at N+1, `mem_we` with 0x00010/0x3C at N+2, never both high.
- **Full FIFO**: three back-to-back pushes with `enable=0` -> first two accepted, `wr_ready=0` on the third, `wr_count=2`. Raise `enable` -> entries drain in order and `wr_ready` returns.
- **Blanking**: `disp_active=0` for 8 strobes with 2 entries queued -> no `mem_re`, 8 zero-data `pix_valid` pulses, both writes issued within 3 clk.
- **Sync clear**: `s_rst=1` for one clk with `wr_count=1` -> `wr_count=0` next clk and no `mem_we` issued for the flushed entry.
